// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: EX/MEM-side inputs and MEM/WB-side outputs of the memory-access stage.
interface mem_access_stage_if #(parameter int S = 15);
  logic [S:0] InUpper, InLower, InWord;
  logic [7:0] InByte;
  logic [3:0] InCtrlM, InCtrlW, For;
  logic [S:0] OutResult, OutUpper;
  logic [3:0] OutCtrlW, Forward;
  logic       OutFault;
  modport master (output InUpper, InLower, InWord, InByte, InCtrlM, InCtrlW, For,
                  input  OutResult, OutUpper, OutCtrlW, Forward, OutFault);
  modport slave  (input  InUpper, InLower, InWord, InByte, InCtrlM, InCtrlW, For,
                  output OutResult, OutUpper, OutCtrlW, Forward, OutFault);
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage: byte/word loads and stores to a local little-endian memory, one-cycle registered result.
// Optional MEM_ALIGN_CHECK_EN flags and cancels misaligned word accesses.
module mem_access_stage #(
  parameter int S  = 15,
  parameter int AW = 8
) (
  input logic               clk,
  input logic               rst,
  mem_access_stage_if.slave bus
);
  logic [7:0]    r_mem [0:(1<<AW)-1];
  logic [S:0]    r_result, r_upper;
  logic [3:0]    r_ctrl_w, r_fwd;
  logic          r_fault;
  logic [AW-1:0] w_addr, w_a, w_a1;
  logic [S:0]    w_word, w_result;
  logic          w_bub, w_mis, w_wr_w, w_wr_b, w_unused;
  assign w_addr   = bus.InLower[AW-1:0];
  assign w_a      = {w_addr[AW-1:1], 1'b0};
  assign w_a1     = {w_addr[AW-1:1], 1'b1};
  assign w_word   = {r_mem[w_a1], r_mem[w_a]};
  assign w_bub    = bus.InCtrlM == 4'h0;
  assign w_unused = &{1'b0, bus.InLower[S:AW]};
`ifdef MEM_ALIGN_CHECK_EN
  assign w_mis = (bus.InCtrlM == 4'h2 || bus.InCtrlM == 4'h4) && w_addr[0];
`else
  assign w_mis = 1'b0;
`endif
  assign w_wr_w = bus.InCtrlM == 4'h4 && !w_mis;
  assign w_wr_b = bus.InCtrlM == 4'h5;
  always_comb begin
    w_result = w_bub ? '0 :
               (bus.InCtrlM == 4'h2) ? (w_mis ? '0 : w_word) :
               (bus.InCtrlM == 4'h3) ? {{(S-7){1'b0}}, r_mem[w_addr]} :
               bus.InLower;
  end
  // Memory is not reset, but stores are suppressed while rst is held.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_w) begin
      r_mem[w_a]  <= bus.InWord[7:0];
      r_mem[w_a1] <= bus.InWord[15:8];
    end else if (!rst && w_wr_b) begin
      r_mem[w_addr] <= bus.InByte;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
      r_upper  <= '0;
      r_ctrl_w <= '0;
      r_fwd    <= '0;
      r_fault  <= 1'b0;
    end else begin
      r_result <= w_result;
      r_upper  <= w_bub ? '0 : bus.InUpper;
      r_ctrl_w <= (w_bub || w_mis) ? '0 : bus.InCtrlW;
      r_fwd    <= w_bub ? '0 : bus.For;
      r_fault  <= w_mis;
    end
  end
  assign bus.OutResult = r_result;
  assign bus.OutUpper  = r_upper;
  assign bus.OutCtrlW  = r_ctrl_w;
  assign bus.Forward   = r_fwd;
  assign bus.OutFault  = r_fault;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: random and directed scoreboard bench against a byte-array reference model.
module tb_mem_access_stage;
  typedef struct packed {
    logic [15:0] res, up;
    logic [3:0]  cw, fw;
    logic        flt;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  int n_chk = 0, n_fail = 0;
  exp_t q[$];
  logic [7:0] mm [256];
  mem_access_stage_if bus();
  mem_access_stage dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic exp_t model(input logic [3:0] c, input logic [15:0] lo, up,
                                 input logic [15:0] wd, input logic [7:0] by,
                                 input logic [3:0] cw, fr);
    exp_t e;
    logic [7:0] ad, a;
    logic mis;
    e = '0;
    if (c == 4'h0) return e;
    ad = lo[7:0];
    a = ad & 8'hFE;
`ifdef MEM_ALIGN_CHECK_EN
    mis = (c == 4'h2 || c == 4'h4) && ad[0];
`else
    mis = 1'b0;
`endif
    e.res = lo; e.up = up; e.cw = mis ? 4'h0 : cw; e.fw = fr; e.flt = mis;
    if (c == 4'h2) e.res = mis ? 16'h0 : {mm[a + 8'd1], mm[a]};
    if (c == 4'h3) e.res = {8'h00, mm[ad]};
    if (c == 4'h4 && !mis) begin mm[a] = wd[7:0]; mm[a + 8'd1] = wd[15:8]; end
    if (c == 4'h5) mm[ad] = by;
    return e;
  endfunction
  task automatic op(input logic [3:0] c, input logic [15:0] lo, input logic [15:0] wd = 16'h0,
                    input logic [7:0] by = 8'h0, input logic [15:0] up = 16'h0,
                    input logic [3:0] cw = 4'h0, input logic [3:0] fr = 4'h0);
    @(negedge clk);
    bus.InCtrlM = c; bus.InLower = lo; bus.InWord = wd; bus.InByte = by;
    bus.InUpper = up; bus.InCtrlW = cw; bus.For = fr;
    q.push_back(model(c, lo, up, wd, by, cw, fr));
  endtask
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst && q.size() > 0) begin
      e = q.pop_front();
      chk("result", 32'(bus.OutResult), 32'(e.res));
      chk("upper",  32'(bus.OutUpper),  32'(e.up));
      chk("ctrlw",  32'(bus.OutCtrlW),  32'(e.cw));
      chk("fwd",    32'(bus.Forward),   32'(e.fw));
      chk("fault",  32'(bus.OutFault),  32'(e.flt));
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.InCtrlM = 4'h0; bus.InLower = '0; bus.InWord = '0; bus.InByte = '0;
    bus.InUpper = '0; bus.InCtrlW = '0; bus.For = '0;
    #1;
    chk("reset_result", 32'(bus.OutResult), 32'h0);
    chk("reset_ctrlw",  32'(bus.OutCtrlW),  32'h0);
    chk("reset_fault",  32'(bus.OutFault),  32'h0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 128; i++) op(4'h4, 16'(2 * i), 16'($urandom));
    op(4'h4, 16'h0010, 16'hBEEF, 8'h00, 16'h1, 4'h1, 4'h2);
    op(4'h2, 16'h0010, 16'h0, 8'h0, 16'hAAAA, 4'h3, 4'h4);
    op(4'h3, 16'h0011);
    op(4'h5, 16'h0011, 16'h0, 8'h5A);
    op(4'h2, 16'h0010);
    op(4'h0, 16'h0010, 16'h9999, 8'h77, 16'h5555, 4'h3, 4'h7);
    op(4'h2, 16'h0010);
    op(4'h4, 16'h0020, 16'h1111);
    op(4'h2, 16'h0020);
    op(4'h4, 16'h0021, 16'hCAFE, 8'h0, 16'h0, 4'h5, 4'h6);
    op(4'h2, 16'h0020);
    op(4'h2, 16'h0021, 16'h0, 8'h0, 16'h0, 4'h9, 4'h1);
    op(4'h7, 16'hFFFF, 16'h0, 8'h0, 16'h4321, 4'hF, 4'hF);
    op(4'h2, 16'h00FE);
    op(4'h3, 16'h00FF);
    op(4'h1, 16'hA5A5, 16'h0, 8'h0, 16'h7777, 4'h2, 4'h3);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("async_rst_result", 32'(bus.OutResult), 32'h0);
    chk("async_rst_upper",  32'(bus.OutUpper),  32'h0);
    chk("async_rst_ctrlw",  32'(bus.OutCtrlW),  32'h0);
    chk("async_rst_fwd",    32'(bus.Forward),   32'h0);
    chk("async_rst_fault",  32'(bus.OutFault),  32'h0);
    bus.InCtrlM = 4'h4; bus.InLower = 16'h0040; bus.InWord = 16'hDEAD;
    @(negedge clk); bus.InCtrlM = 4'h5; bus.InLower = 16'h0041; bus.InByte = 8'h33;
    @(negedge clk); bus.InCtrlM = 4'h0;
    rst = 1'b0;
    op(4'h1, 16'h1234, 16'h0, 8'h0, 16'h0, 4'h1, 4'h1);
    op(4'h2, 16'h0040);
    for (int i = 0; i < 400; i++)
      op(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 8'($urandom),
         16'($urandom), 4'($urandom), 4'($urandom));
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
